// File: rtl/seq_detect_pkg.sv
// Shared definitions for the 1011 serial-marker detector: state encoding,
// pattern constant and small decode helpers.
package seq_detect_pkg;

    localparam int STATE_W = 3;
    localparam logic [3:0] PATTERN = 4'b1011;

    // Each state names how much of PATTERN (MSB first) has been matched.
    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    function automatic logic is_detect(input state_t s);
        return (s == S4);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_moore_fsm.sv
// Moore detector for the serial pattern 1011 with a saturating count of
// detections; o_state mirrors the state register for debug visibility.
module seq_detect_moore_fsm
    import seq_detect_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_seq,
    output logic               o_out,
    output logic [CNT_W-1:0]   o_cnt,
    output logic [STATE_W-1:0] o_state
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // On a miss, fall back to the longest suffix that is still a prefix.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0: state_d = i_seq ? S1 : S0;
            S1: state_d = i_seq ? S1 : S2;
            S2: state_d = i_seq ? S3 : S0;
            S3: state_d = i_seq ? S4 : S2;
            S4: begin
                if (i_seq) begin
                    state_d = S1;
                end else if (OVERLAP != 0) begin
                    state_d = S2;
                end else begin
                    state_d = S0;
                end
            end
            default: state_d = S0;
        endcase
    end

    assign o_out   = is_detect(state_q);
    assign o_state = state_q;

    // Counting on the entry into S4 keeps o_cnt in step with o_out rising.
    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk (i_clk),
        .clr (i_rst),
        .inc (is_detect(state_d)),
        .cnt (o_cnt)
    );

endmodule

// File: tb/tb_seq_detect_moore_fsm.sv
// Directed-vector bench for seq_detect_moore_fsm: three parameterisations,
// expected state/out/count pushed per edge and checked by a negedge monitor.
module tb_seq_detect_moore_fsm;

    logic clk = 1'b0;

    logic       seq_v [3];
    logic       rst_v [3];
    logic       out_v [3];
    logic [2:0] st_v  [3];
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    // Expected entry: {dut index[1:0], state[2:0], out, count[7:0]}
    logic [13:0] exp_q [$];
    string       name_q[$];

    int checks = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seq_detect_moore_fsm #(.OVERLAP(1), .CNT_W(8)) dut_ov (
        .i_clk(clk), .i_rst(rst_v[0]), .i_seq(seq_v[0]),
        .o_out(out_v[0]), .o_cnt(cnt0), .o_state(st_v[0])
    );

    seq_detect_moore_fsm #(.OVERLAP(0), .CNT_W(8)) dut_no (
        .i_clk(clk), .i_rst(rst_v[1]), .i_seq(seq_v[1]),
        .o_out(out_v[1]), .o_cnt(cnt1), .o_state(st_v[1])
    );

    seq_detect_moore_fsm #(.OVERLAP(1), .CNT_W(2)) dut_c2 (
        .i_clk(clk), .i_rst(rst_v[2]), .i_seq(seq_v[2]),
        .o_out(out_v[2]), .o_cnt(cnt2), .o_state(st_v[2])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every negedge it consumes the entry pushed at the preceding posedge.
    initial begin
        logic [13:0] e;
        string       nm;
        int          idx;
        int          act_cnt;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                idx = int'(e[13:12]);
                case (idx)
                    0:       act_cnt = int'(cnt0);
                    1:       act_cnt = int'(cnt1);
                    default: act_cnt = int'(cnt2);
                endcase
                check({nm, ".state"}, int'(st_v[idx]), int'(e[11:9]));
                check({nm, ".out"},   int'(out_v[idx]), int'(e[8]));
                check({nm, ".cnt"},   act_cnt, int'(e[7:0]));
            end
        end
    end

    // Bits: '0'/'1' data, 'r' reset with seq=1, 'R' reset with seq=0.
    // Per step: expected state digit, out digit and count digit after that edge.
    task automatic run_vec(input int idx, input string tag, input string bits,
                           input string states, input string outs, input string cnts);
        for (int i = 0; i < bits.len(); i++) begin
            for (int d = 0; d < 3; d++) begin
                rst_v[d] = (d != idx);
                seq_v[d] = 1'b0;
            end
            case (bits[i])
                "r":     begin rst_v[idx] = 1'b1; seq_v[idx] = 1'b1; end
                "R":     begin rst_v[idx] = 1'b1; seq_v[idx] = 1'b0; end
                "1":     begin rst_v[idx] = 1'b0; seq_v[idx] = 1'b1; end
                default: begin rst_v[idx] = 1'b0; seq_v[idx] = 1'b0; end
            endcase
            @(posedge clk);
            exp_q.push_back({2'(idx), 3'(states[i] - "0"), 1'(outs[i] - "0"),
                             8'(cnts[i] - "0")});
            name_q.push_back($sformatf("%s[%0d]", tag, i));
            #1;
        end
    endtask

    initial begin
        int wait_cycles;
        for (int d = 0; d < 3; d++) begin
            rst_v[d] = 1'b1;
            seq_v[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        run_vec(0, "reset",     "rR",        "00",        "00",        "00");
        run_vec(0, "basic",     "101100",    "123420",    "000100",    "000111");
        run_vec(0, "ovl1",      "r1011011",  "01234234",  "00001001",  "00001112");
        run_vec(1, "ovl0",      "r1011011",  "01234011",  "00001000",  "00001111");
        run_vec(1, "ovl0_s4_1", "r10111011", "012341234", "000010001", "000011112");
        run_vec(0, "fallback",  "r101011",   "0123234",   "0000001",   "0000001");
        run_vec(0, "no_match",  "r1110011",  "01112011",  "00000000",  "00000000");
        run_vec(0, "mid_reset", "r101r11011", "0123011234", "0000000001", "0000000001");
        run_vec(2, "saturate",  "r1011011011011011",
                "01234234234234234", "00001001001001001", "00001112223333333");
        run_vec(0, "reset_end", "R",         "0",         "0",         "0");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
